// File: rtl/riscv_insn_compressor_if.sv
// Stream bundle between the loader/assembler path and instruction memory.
// The input side carries 32-bit RV32I instructions and the output side
// carries densely packed 32-bit memory words.
interface riscv_insn_compressor_if;
  // Instruction input channel
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic        in_last;

  // Packed-word output channel
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  // Producer/consumer environment around the compressor
  modport master (
    output in_valid, in_insn, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The compressor itself
  modport slave (
    input  in_valid, in_insn, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/riscv_insn_compressor.sv
// Streaming RVC compressor. Each accepted RV32I instruction is re-encoded
// as a 16-bit RVC parcel when it falls in the supported subset, otherwise
// it is kept as a 32-bit parcel. Parcels are packed little-endian into
// 32-bit words (lower halfword = earlier parcel). A stream ending on a
// half-filled word is padded with C.NOP (16'h0001) so the decompressor on
// the fetch side sees only legal instructions.
module riscv_insn_compressor #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 compress_en,
  riscv_insn_compressor_if.slave bus,
  output logic [CNT_W-1:0]     saved_cnt
);

  // RV32I major opcodes of the instructions we know how to shrink
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // Padding parcel used to fill the upper half of a final word
  localparam logic [15:0] C_NOP   = 16'h0001;

  // Packing state: EMPTY = no pending half, HALF = one parcel half waiting
  // for a partner, FLUSH = upper half of a trailing 32-bit parcel still
  // has to go out in its own padded word.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FLUSH = 2'd2
  } pack_state_t;

  pack_state_t      state;
  logic [15:0]      pending;
  logic             out_valid_q;
  logic [31:0]      out_data_q;
  logic             out_last_q;
  logic [CNT_W-1:0] saved_cnt_q;

  // ---------------------------------------------------------------------
  // Instruction field extraction
  // ---------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [11:0] imm_i;
  logic [11:0] imm_s;

  assign opcode = bus.in_insn[6:0];
  assign rd     = bus.in_insn[11:7];
  assign funct3 = bus.in_insn[14:12];
  assign rs1    = bus.in_insn[19:15];
  assign rs2    = bus.in_insn[24:20];
  assign funct7 = bus.in_insn[31:25];
  assign imm_i  = bus.in_insn[31:20];
  assign imm_s  = {bus.in_insn[31:25], bus.in_insn[11:7]};

  // Instruction class qualifiers
  logic is_addi, is_lw, is_sw, is_add;

  assign is_addi = (opcode == OP_IMM)   && (funct3 == 3'b000);
  assign is_lw   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
  assign is_add  = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0);

  // The 3-bit register fields of the CIW/CL/CS formats reach only x8..x15
  logic rd_prime, rs1_prime, rs2_prime;

  assign rd_prime  = (rd[4:3]  == 2'b01);
  assign rs1_prime = (rs1[4:3] == 2'b01);
  assign rs2_prime = (rs2[4:3] == 2'b01);

  // Immediate range checks
  //   imm6_ok    : sign-extended value fits in 6 bits (-32..31)
  //   spn_imm_ok : 0 < imm < 1024, word aligned
  //   lw_off_ok  : 0 <= off < 128, word aligned (load offset)
  //   sw_off_ok  : same limits for the store offset
  logic imm6_ok, spn_imm_ok, lw_off_ok, sw_off_ok;

  assign imm6_ok    = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);
  assign spn_imm_ok = (imm_i[11:10] == 2'b00) && (imm_i[1:0] == 2'b00) &&
                      (imm_i != 12'h000);
  assign lw_off_ok  = (imm_i[11:7] == 5'h00) && (imm_i[1:0] == 2'b00);
  assign sw_off_ok  = (imm_s[11:7] == 5'h00) && (imm_s[1:0] == 2'b00);

  // ---------------------------------------------------------------------
  // Compression: first matching rule wins, nothing matches when disabled
  // ---------------------------------------------------------------------
  logic        c_valid;
  logic [15:0] c_parcel;

  // Combinational RVC encoder for the instruction on the input port
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the if-chain leaves it unassigned and infers a latch.
    c_valid  = 1'b0;
    c_parcel = 16'h0000;
    if (compress_en) begin
      if (is_addi && (rs1 == 5'd2) && rd_prime && spn_imm_ok) begin
        // C.ADDI4SPN
        c_valid  = 1'b1;
        c_parcel = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3],
                    rd[2:0], 2'b00};
      end else if (is_lw && rd_prime && rs1_prime && lw_off_ok) begin
        // C.LW
        c_valid  = 1'b1;
        c_parcel = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6],
                    rd[2:0], 2'b00};
      end else if (is_sw && rs2_prime && rs1_prime && sw_off_ok) begin
        // C.SW
        c_valid  = 1'b1;
        c_parcel = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6],
                    rs2[2:0], 2'b00};
      end else if (is_addi && (rd == 5'd0) && (rs1 == 5'd0) && (imm_i == 12'h000)) begin
        // Canonical NOP
        c_valid  = 1'b1;
        c_parcel = C_NOP;
      end else if (is_addi && (rs1 == 5'd0) && (rd != 5'd0) && imm6_ok) begin
        // C.LI
        c_valid  = 1'b1;
        c_parcel = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_addi && (rd == rs1) && (rd != 5'd0) &&
                   (imm_i != 12'h000) && imm6_ok) begin
        // C.ADDI
        c_valid  = 1'b1;
        c_parcel = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
      end else if (is_add && (rs1 == 5'd0) && (rd != 5'd0) && (rs2 != 5'd0)) begin
        // C.MV
        c_valid  = 1'b1;
        c_parcel = {4'b1000, rd, rs2, 2'b10};
      end else if (is_add && (rd == rs1) && (rd != 5'd0) && (rs2 != 5'd0)) begin
        // C.ADD
        c_valid  = 1'b1;
        c_parcel = {4'b1001, rd, rs2, 2'b10};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  // The output register can take a new word when it is empty or being
  // drained this cycle. In FLUSH the slot is reserved for the padded tail
  // word, so no new instruction is taken.
  logic slot_free;
  logic accept;

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state != FLUSH) && slot_free;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign saved_cnt     = saved_cnt_q;

  // ---------------------------------------------------------------------
  // Packing FSM with registered outputs and statistics counter
  // ---------------------------------------------------------------------
  // Pack accepted parcels into output words and count compressed ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Reset drops any pending half and any stalled output word, so no
      // partial word can escape after reset is released.
      state       <= EMPTY;
      pending     <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_last_q  <= 1'b0;
      saved_cnt_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // statement below sees the pre-edge values; the later assignment to
      // out_valid_q simply overrides this default drain when a word is
      // produced in the same cycle.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // Saturating count of instructions that shrank to 16 bits
      if (accept && c_valid && (saved_cnt_q != {CNT_W{1'b1}})) begin
        saved_cnt_q <= saved_cnt_q + CNT_W'(1);
      end

      case (state)
        EMPTY: begin
          if (accept) begin
            if (c_valid) begin
              if (bus.in_last) begin
                // Lone parcel at end of stream: pad with C.NOP
                out_valid_q <= 1'b1;
                out_data_q  <= {C_NOP, c_parcel};
                out_last_q  <= 1'b1;
              end else begin
                // Hold the parcel until its partner arrives; any stalled
                // word keeps its out_valid untouched.
                pending <= c_parcel;
                state   <= HALF;
              end
            end else begin
              // Word-aligned 32-bit parcel goes straight out
              out_valid_q <= 1'b1;
              out_data_q  <= bus.in_insn;
              out_last_q  <= bus.in_last;
            end
          end
        end

        HALF: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            if (c_valid) begin
              // Two 16-bit parcels complete the word
              out_data_q <= {c_parcel, pending};
              out_last_q <= bus.in_last;
              state      <= EMPTY;
            end else begin
              // 32-bit parcel straddles two words: low half goes now,
              // high half becomes the new pending half.
              out_data_q <= {bus.in_insn[15:0], pending};
              out_last_q <= 1'b0;
              pending    <= bus.in_insn[31:16];
              if (bus.in_last) begin
                state <= FLUSH;
              end
            end
          end
        end

        FLUSH: begin
          // Emit the trailing high half padded with C.NOP
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {C_NOP, pending};
            out_last_q  <= 1'b1;
            state       <= EMPTY;
          end
        end

        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule
